// File: rtl/core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// core_pipe_ctrl
//
// Pipeline sequencer for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
//
// The block keeps a valid bit for ID, EX, MEM and WB. It also keeps the
// register metadata each later stage needs for hazard detection. From that
// state it produces:
//   - the PC and IF/ID load enables,
//   - the load-use interlock,
//   - the taken-branch flush,
//   - the data-memory wait freeze,
//   - the EX operand forwarding selects.
//
// Ports
//   CLK, RST_N            clock, synchronous active-low reset
//   FETCH_READY           instruction memory has a valid INST this cycle
//   ID_RD/RS1/RS2         register numbers of the instruction in ID
//   ID_WE/LOAD/MEMOP      class flags of the instruction in ID
//   EX_BR_TAKEN           control transfer in EX redirects the PC
//   MEM_ACK               data memory completes the access in MEM
//   PC_WE, IFID_WE        front-end register enables
//   ID_V..WB_V            per-stage valid bits
//   STALL_LOADUSE         load-use bubble inserted this cycle
//   FLUSH                 IF and ID contents killed this cycle
//   MEM_BUSY              pipeline frozen waiting on MEM_ACK
//   FWD_A, FWD_B          EX operand source: 00 regfile, 01 MEM, 10 WB
//   STALL_CYCLES          wrapping count of cycles stalled by either hazard
// ---------------------------------------------------------------------------
module core_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             FETCH_READY,
  input  logic [4:0]       ID_RD,
  input  logic [4:0]       ID_RS1,
  input  logic [4:0]       ID_RS2,
  input  logic             ID_WE,
  input  logic             ID_LOAD,
  input  logic             ID_MEMOP,
  input  logic             EX_BR_TAKEN,
  input  logic             MEM_ACK,
  output logic             PC_WE,
  output logic             IFID_WE,
  output logic             ID_V,
  output logic             EX_V,
  output logic             MEM_V,
  output logic             WB_V,
  output logic             STALL_LOADUSE,
  output logic             FLUSH,
  output logic             MEM_BUSY,
  output logic [1:0]       FWD_A,
  output logic [1:0]       FWD_B,
  output logic [CNT_W-1:0] STALL_CYCLES
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Stage valid bits.
  logic id_v_q, ex_v_q, mem_v_q, wb_v_q;

  // EX stage metadata.
  logic [4:0] ex_rd_q, ex_rs1_q, ex_rs2_q;
  logic       ex_we_q, ex_load_q, ex_memop_q;

  // MEM stage metadata.
  logic [4:0] mem_rd_q;
  logic       mem_we_q, mem_memop_q;

  // WB stage metadata.
  logic [4:0] wb_rd_q;
  logic       wb_we_q;

  logic [CNT_W-1:0] stall_cnt_q;

  // Hazard conditions.
  logic mem_stall;
  logic loaduse_raw;
  logic flush;
  logic loaduse;

  // A store or load sitting in MEM without an ack freezes everything
  // behind it, and WB receives a bubble.
  assign mem_stall = mem_v_q & mem_memop_q & ~MEM_ACK;

  assign loaduse_raw = id_v_q & ex_v_q & ex_load_q & (ex_rd_q != 5'd0) &
                       ((ex_rd_q == ID_RS1) | (ex_rd_q == ID_RS2));

  // A redirect is deferred while frozen. EX keeps EX_BR_TAKEN asserted
  // until the freeze ends.
  assign flush = ex_v_q & EX_BR_TAKEN & ~mem_stall;

  // The interlock only takes effect when neither higher-priority event
  // owns the cycle.
  assign loaduse = loaduse_raw & ~mem_stall & ~flush;

  // Front-end enables, by priority: freeze > flush > interlock > advance.
  logic pc_we, ifid_we;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the if/else chain leaves it unassigned and infers a latch.
    pc_we   = 1'b0;
    ifid_we = 1'b0;
    if (mem_stall) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else if (flush) begin
      // The PC takes the branch target whether or not a fetch is ready.
      // The instruction being fetched is discarded.
      pc_we   = 1'b1;
      ifid_we = 1'b0;
    end else if (loaduse) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
    end else begin
      pc_we   = FETCH_READY;
      ifid_we = FETCH_READY;
    end
  end

  // The nearest producer wins. Register x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       m_v,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_v,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    if (m_v && m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
      return FWD_MEM;
    end else if (w_v && w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  logic [1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (ex_v_q) begin
      fwd_a = fwd_sel(ex_rs1_q, mem_v_q, mem_we_q, mem_rd_q,
                      wb_v_q, wb_we_q, wb_rd_q);
      fwd_b = fwd_sel(ex_rs2_q, mem_v_q, mem_we_q, mem_rd_q,
                      wb_v_q, wb_we_q, wb_rd_q);
    end
  end

  // Combinational outputs are held low while reset is asserted.
  assign PC_WE         = RST_N & pc_we;
  assign IFID_WE       = RST_N & ifid_we;
  assign STALL_LOADUSE = RST_N & loaduse;
  assign FLUSH         = RST_N & flush;
  assign MEM_BUSY      = RST_N & mem_stall;
  assign FWD_A         = RST_N ? fwd_a : FWD_RF;
  assign FWD_B         = RST_N ? fwd_b : FWD_RF;

  assign ID_V         = id_v_q;
  assign EX_V         = ex_v_q;
  assign MEM_V        = mem_v_q;
  assign WB_V         = wb_v_q;
  assign STALL_CYCLES = stall_cnt_q;

  // NOTE: state is written with non-blocking assignments only. Every stage
  // then samples its predecessor's pre-edge value, and the pipeline shifts
  // by exactly one stage per clock. Reset is synchronous, so it lives
  // inside the clocked branch.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      id_v_q      <= 1'b0;
      ex_v_q      <= 1'b0;
      mem_v_q     <= 1'b0;
      wb_v_q      <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_rs1_q    <= 5'd0;
      ex_rs2_q    <= 5'd0;
      ex_we_q     <= 1'b0;
      ex_load_q   <= 1'b0;
      ex_memop_q  <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_we_q    <= 1'b0;
      mem_memop_q <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if (mem_stall || loaduse) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end

      if (mem_stall) begin
        // ID, EX and MEM hold their contents. WB drains to a bubble.
        wb_v_q <= 1'b0;
      end else begin
        // MEM and WB advance in every non-frozen cycle. On a flush the
        // branch itself moves on from EX into MEM.
        wb_v_q      <= mem_v_q;
        wb_rd_q     <= mem_rd_q;
        wb_we_q     <= mem_we_q;
        mem_v_q     <= ex_v_q;
        mem_rd_q    <= ex_rd_q;
        mem_we_q    <= ex_we_q;
        mem_memop_q <= ex_memop_q;

        if (flush) begin
          id_v_q <= 1'b0;
          ex_v_q <= 1'b0;
        end else if (loaduse) begin
          // ID keeps the consumer, and EX receives the bubble.
          ex_v_q <= 1'b0;
        end else begin
          id_v_q     <= FETCH_READY;
          ex_v_q     <= id_v_q;
          ex_rd_q    <= ID_RD;
          ex_rs1_q   <= ID_RS1;
          ex_rs2_q   <= ID_RS2;
          ex_we_q    <= ID_WE;
          ex_load_q  <= ID_LOAD;
          ex_memop_q <= ID_MEMOP;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_core_pipe_ctrl
//
// Cycle-directed bench for core_pipe_ctrl.
//
// Each stimulus cycle drives the inputs just after the falling edge and
// queues the outputs the pipeline must show during that cycle. The
// expected values are derived by hand from the instruction stream.
// A monitor samples the DUT 1 time unit before the next rising edge.
// At that point the registered state reflects the previous edge and the
// combinational outputs reflect the current inputs. The monitor then
// pops the queue and compares.
// ---------------------------------------------------------------------------
module tb_core_pipe_ctrl;

  localparam int CNT_W = 32;

  logic             CLK;
  logic             RST_N;
  logic             FETCH_READY;
  logic [4:0]       ID_RD, ID_RS1, ID_RS2;
  logic             ID_WE, ID_LOAD, ID_MEMOP;
  logic             EX_BR_TAKEN, MEM_ACK;
  logic             PC_WE, IFID_WE;
  logic             ID_V, EX_V, MEM_V, WB_V;
  logic             STALL_LOADUSE, FLUSH, MEM_BUSY;
  logic [1:0]       FWD_A, FWD_B;
  logic [CNT_W-1:0] STALL_CYCLES;

  core_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .FETCH_READY   (FETCH_READY),
    .ID_RD         (ID_RD),
    .ID_RS1        (ID_RS1),
    .ID_RS2        (ID_RS2),
    .ID_WE         (ID_WE),
    .ID_LOAD       (ID_LOAD),
    .ID_MEMOP      (ID_MEMOP),
    .EX_BR_TAKEN   (EX_BR_TAKEN),
    .MEM_ACK       (MEM_ACK),
    .PC_WE         (PC_WE),
    .IFID_WE       (IFID_WE),
    .ID_V          (ID_V),
    .EX_V          (EX_V),
    .MEM_V         (MEM_V),
    .WB_V          (WB_V),
    .STALL_LOADUSE (STALL_LOADUSE),
    .FLUSH         (FLUSH),
    .MEM_BUSY      (MEM_BUSY),
    .FWD_A         (FWD_A),
    .FWD_B         (FWD_B),
    .STALL_CYCLES  (STALL_CYCLES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst_n;
    logic       fr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       we;
    logic       ld;
    logic       mo;
    logic       br;
    logic       ack;
  } stim_t;

  // v is {ID_V, EX_V, MEM_V, WB_V}.
  typedef struct packed {
    logic             pc_we;
    logic [3:0]       v;
    logic             lu;
    logic             fl;
    logic             busy;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction presented in ID. The default is fetch ready,
  // memory acking, and no branch.
  function automatic stim_t ins(input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic we,
                                input logic ld, input logic mo);
    stim_t s;
    s.rst_n = 1'b1;
    s.fr    = 1'b1;
    s.rd    = rd;
    s.rs1   = rs1;
    s.rs2   = rs2;
    s.we    = we;
    s.ld    = ld;
    s.mo    = mo;
    s.br    = 1'b0;
    s.ack   = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s, input string tag, input logic pc_we,
                     input logic [3:0] v, input logic lu, input logic fl,
                     input logic busy, input logic [1:0] fa,
                     input logic [1:0] fb, input logic [CNT_W-1:0] sc);
    exp_t e;
    @(negedge CLK);
    RST_N       = s.rst_n;
    FETCH_READY = s.fr;
    ID_RD       = s.rd;
    ID_RS1      = s.rs1;
    ID_RS2      = s.rs2;
    ID_WE       = s.we;
    ID_LOAD     = s.ld;
    ID_MEMOP    = s.mo;
    EX_BR_TAKEN = s.br;
    MEM_ACK     = s.ack;
    e.pc_we = pc_we;
    e.v     = v;
    e.lu    = lu;
    e.fl    = fl;
    e.busy  = busy;
    e.fa    = fa;
    e.fb    = fb;
    e.sc    = sc;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Monitor: sample before the rising edge and compare against the queue.
  exp_t  mon_e;
  string mon_t;

  always @(negedge CLK) begin
    #4;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check({mon_t, ":PC_WE"}, PC_WE, mon_e.pc_we);
      // IF/ID follows the PC enable except on a redirect.
      if (!mon_e.fl) check({mon_t, ":IFID_WE"}, IFID_WE, mon_e.pc_we);
      check({mon_t, ":ID_V"}, ID_V, mon_e.v[3]);
      check({mon_t, ":EX_V"}, EX_V, mon_e.v[2]);
      check({mon_t, ":MEM_V"}, MEM_V, mon_e.v[1]);
      check({mon_t, ":WB_V"}, WB_V, mon_e.v[0]);
      check({mon_t, ":STALL_LOADUSE"}, STALL_LOADUSE, mon_e.lu);
      check({mon_t, ":FLUSH"}, FLUSH, mon_e.fl);
      check({mon_t, ":MEM_BUSY"}, MEM_BUSY, mon_e.busy);
      check({mon_t, ":FWD_A"}, FWD_A, mon_e.fa);
      check({mon_t, ":FWD_B"}, FWD_B, mon_e.fb);
      check({mon_t, ":STALL_CYCLES"}, STALL_CYCLES, mon_e.sc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  stim_t s;
  stim_t nop;

  initial begin
    nop = ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b0; FETCH_READY = 1'b0; ID_RD = '0; ID_RS1 = '0; ID_RS2 = '0;
    ID_WE = 1'b0; ID_LOAD = 1'b0; ID_MEMOP = 1'b0;
    EX_BR_TAKEN = 1'b0; MEM_ACK = 1'b1;
    repeat (2) @(negedge CLK);

    // Reset, then a hazard-free ADDI stream filling the pipe.
    s = nop; s.rst_n = 1'b0; s.fr = 1'b0;
    cyc(s, "rst", 0, 4'b0000, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(nop, "fill1", 1, 4'b0000, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(1, 0, 0, 1, 0, 0), "fill2", 1, 4'b1000, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(2, 0, 0, 1, 0, 0), "fill3", 1, 4'b1100, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(3, 0, 0, 1, 0, 0), "fill4", 1, 4'b1110, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(4, 0, 0, 1, 0, 0), "fill5", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 0);

    // LW x5 followed by a consumer of x5.
    cyc(ins(5, 0, 0, 1, 1, 1), "lw_id", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(6, 5, 0, 1, 0, 0), "loaduse", 0, 4'b1111, 1, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(6, 5, 0, 1, 0, 0), "lu_bubble", 1, 4'b1011, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(7, 0, 0, 1, 0, 0), "fwd_a_wb", 1, 4'b1101, 0, 0, 0, 2'b10, 2'b00, 1);

    // Forwarding on rs2 = 3.
    cyc(ins(3, 0, 0, 1, 0, 0), "c_addx3", 1, 4'b1110, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(9, 0, 3, 1, 0, 0), "c_use1", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(0, 0, 0, 1, 0, 0), "fwd_b_mem", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b01, 1);
    cyc(ins(9, 0, 3, 1, 0, 0), "c_use2", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(3, 0, 0, 1, 0, 0), "fwd_b_rd0", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(3, 0, 0, 1, 0, 0), "c_addx3b", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(9, 0, 3, 1, 0, 0), "c_use3", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(3, 0, 0, 0, 0, 0), "fwd_b_both", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b01, 1);
    cyc(ins(8, 0, 0, 1, 0, 0), "c_fill", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(9, 0, 3, 1, 0, 0), "c_use4", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(nop, "fwd_b_nowe", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(3, 0, 0, 1, 0, 0), "c_addx3c", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(nop, "c_gap1", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(ins(9, 3, 3, 1, 0, 0), "c_use5", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(nop, "fwd_ab_wb", 1, 4'b1111, 0, 0, 0, 2'b10, 2'b10, 1);

    // Taken branch in EX with no fetch ready.
    cyc(nop, "br_id", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 1);
    s = ins(10, 0, 0, 1, 0, 0); s.fr = 1'b0; s.br = 1'b1;
    cyc(s, "flush", 1, 4'b1111, 0, 1, 0, 2'b00, 2'b00, 1);
    s = nop; s.fr = 1'b0;
    cyc(s, "post_flush", 0, 4'b0011, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(nop, "refill_a", 1, 4'b0001, 0, 0, 0, 2'b00, 2'b00, 1);

    // SW in MEM stalls 3 cycles with a taken branch waiting in EX.
    cyc(ins(0, 0, 0, 0, 0, 1), "sw_id", 1, 4'b1000, 0, 0, 0, 2'b00, 2'b00, 1);
    cyc(nop, "br_id2", 1, 4'b1100, 0, 0, 0, 2'b00, 2'b00, 1);
    s = ins(11, 0, 0, 1, 0, 0); s.ack = 1'b0; s.br = 1'b1;
    cyc(s, "busy1", 0, 4'b1110, 0, 0, 1, 2'b00, 2'b00, 1);
    cyc(s, "busy2", 0, 4'b1110, 0, 0, 1, 2'b00, 2'b00, 2);
    cyc(s, "busy3", 0, 4'b1110, 0, 0, 1, 2'b00, 2'b00, 3);
    s.ack = 1'b1;
    cyc(s, "late_flush", 1, 4'b1110, 0, 1, 0, 2'b00, 2'b00, 4);
    cyc(nop, "post_late", 1, 4'b0011, 0, 0, 0, 2'b00, 2'b00, 4);

    // Reset asserted in the middle of a MEM stall.
    cyc(ins(0, 0, 0, 0, 0, 1), "sw_id2", 1, 4'b1001, 0, 0, 0, 2'b00, 2'b00, 4);
    cyc(ins(12, 0, 0, 1, 0, 0), "f2", 1, 4'b1100, 0, 0, 0, 2'b00, 2'b00, 4);
    s = ins(13, 0, 0, 1, 0, 0); s.ack = 1'b0;
    cyc(s, "busy_pre_rst", 0, 4'b1110, 0, 0, 1, 2'b00, 2'b00, 4);
    s.rst_n = 1'b0;
    cyc(s, "rst_in_stall", 0, 4'b1110, 0, 0, 0, 2'b00, 2'b00, 5);
    s = nop; s.ack = 1'b0;
    cyc(s, "post_rst", 1, 4'b0000, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(1, 0, 0, 1, 0, 0), "refill1", 1, 4'b1000, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(2, 0, 0, 1, 0, 0), "refill2", 1, 4'b1100, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(3, 0, 0, 1, 0, 0), "refill3", 1, 4'b1110, 0, 0, 0, 2'b00, 2'b00, 0);
    cyc(ins(4, 0, 0, 1, 0, 0), "refill4", 1, 4'b1111, 0, 0, 0, 2'b00, 2'b00, 0);

    @(negedge CLK);
    #6;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
